// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding sequencer for the 5-stage MiniRISC-V pipeline
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             pc_redirect,
    output logic             hazard,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);
    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT - 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             memstall, load_use, stall_inc;

    assign memstall = dmem_req && !dmem_ready;
    assign load_use = ex_memread && ex_rd != 5'd0 &&
                      ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));

    // x0 never forwards; MEM is the younger producer so it wins over WB
    assign fwd_a = (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b10 :
                   (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b01 : 2'b00;
    assign fwd_b = (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b10 :
                   (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b01 : 2'b00;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        pc_redirect = 1'b0;
        hazard      = 1'b0;
        flush       = 1'b0;
        stall_inc   = 1'b0;
        if (rst_n && memstall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
            stall_inc   = 1'b1;
        end else if (rst_n && ex_redirect) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush       = 1'b1;
        end else if (rst_n && load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            hazard     = 1'b1;
            stall_inc  = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        if (state_q == RUN) begin
            if (memstall) begin
                state_d = MEM_WAIT;
                wait_d  = '0;
            end
        end else if (dmem_ready) begin
            state_d = RUN;
        end else begin
            timeout_d = timeout_q || (wait_q == WAIT_MAX);
            wait_d    = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
        end
        stall_d = (stall_inc && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d = (flush && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
    assign mem_timeout = timeout_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks against a cycle-level behavioural model
module tb_pipeline_hazard_ctrl;
    localparam int T = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_memread, ex_redirect;
    logic mem_regwrite, wb_regwrite, dmem_req, dmem_ready;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, memwb_flush, pc_redirect, hazard, flush;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_count, flush_count;
    logic mem_timeout;

    int total = 0;
    int bad = 0;

    // model state: waiting flag, wait cycles elapsed, sticky timeout, counters
    bit m_wait;
    int m_wc, m_sc, m_fc;
    bit m_to;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .pc_redirect(pc_redirect), .hazard(hazard), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count), .flush_count(flush_count),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic bit m_lu();
        return ex_memread && ex_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {pc,ifid,idex,exmem,memwb enables, ifid/idex/memwb flush, pc_redirect, hazard, flush, fwd_a, fwd_b}
    function automatic logic [14:0] m_ctrl();
        logic [10:0] c;
        bit ms;
        ms = dmem_req && !dmem_ready;
        c = 11'b11111_000_000;
        if (rst_n) begin
            if (ms) c = 11'b00000_001_000;
            else if (ex_redirect) c = 11'b11111_110_101;
            else if (m_lu()) c = 11'b00111_010_010;
        end
        return {c, m_fwd(ex_rs1), m_fwd(ex_rs2)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_edge();
        bit ms;
        ms = dmem_req && !dmem_ready;
        if (!rst_n) begin
            m_wait = 0; m_wc = 0; m_sc = 0; m_fc = 0; m_to = 0;
        end else begin
            if (ms || (!ex_redirect && m_lu())) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            if (!ms && ex_redirect) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
            if (!m_wait) begin
                if (ms) begin m_wait = 1; m_wc = 0; end
            end else if (dmem_ready) begin
                m_wait = 0;
            end else begin
                if (m_wc == T - 1) m_to = 1;
                m_wc = (m_wc < T - 1) ? m_wc + 1 : T - 1;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("ctrl", {17'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                     memwb_flush, pc_redirect, hazard, flush, fwd_a, fwd_b}, {17'd0, m_ctrl()});
        chk("stall_count", 32'(stall_count), 32'(m_sc));
        chk("flush_count", 32'(flush_count), 32'(m_fc));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0; ex_redirect = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
        dmem_req = 0; dmem_ready = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        dmem_req = 1; dmem_ready = 0; ex_redirect = 1;
        #1;
        chk("reset_enables", {31'd0, pc_en & memwb_en & ~memwb_flush & ~flush}, 32'd1);
        cyc(); cyc();
        chk("reset_counts", 32'(stall_count) + 32'(flush_count) + 32'(mem_timeout), 32'd0);
        idle(); rst_n = 1;
        cyc();
        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        #1;
        chk("lu_hazard", {29'd0, hazard, pc_en, idex_flush}, {29'd0, 3'b101});
        cyc();
        chk("lu_stall_count", 32'(stall_count), 32'd1);
        ex_memread = 0;
        #1;
        chk("lu_release", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'h1f);
        cyc();
        ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        #1;
        chk("x0_no_stall", 32'(hazard), 32'd0);
        cyc();
        ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 0;
        #1;
        chk("unused_rs2", 32'(hazard), 32'd0);
        cyc();
        ex_rd = 5; id_rs1 = 5; ex_redirect = 1;
        #1;
        chk("redirect_lu", {26'd0, flush, pc_redirect, ifid_flush, idex_flush, hazard, pc_en},
            {26'd0, 6'b111101});
        cyc();
        chk("redirect_count", 32'(flush_count), 32'd1);
        idle();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("memwait_frozen", {26'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, memwb_flush},
                32'd1);
            cyc();
        end
        dmem_ready = 1;
        cyc();
        idle();
        cyc();
        chk("memwait_stalls", 32'(stall_count), 32'd4);
        chk("memwait_no_timeout", 32'(mem_timeout), 32'd0);
        ex_rs1 = 3; mem_rd = 3; wb_rd = 3; mem_regwrite = 1; wb_regwrite = 1;
        #1;
        chk("fwd_mem", 32'(fwd_a), 32'd2);
        cyc();
        mem_regwrite = 0;
        #1;
        chk("fwd_wb", 32'(fwd_a), 32'd1);
        cyc();
        ex_rs2 = 0; mem_rd = 0; mem_regwrite = 1;
        #1;
        chk("fwd_x0", 32'(fwd_b), 32'd0);
        cyc();
        idle();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < T; i++) cyc();
        chk("timeout_not_yet", 32'(mem_timeout), 32'd0);
        cyc(); cyc();
        chk("timeout_set", 32'(mem_timeout), 32'd1);
        dmem_ready = 1;
        cyc(); cyc();
        chk("timeout_sticky", 32'(mem_timeout), 32'd1);
        rst_n = 0;
        cyc();
        rst_n = 1;
        chk("timeout_cleared", 32'(mem_timeout), 32'd0);
        idle();
        ex_memread = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
        for (int i = 0; i < 20; i++) cyc();
        chk("stall_saturate", 32'(stall_count), CMAX);
        idle(); ex_redirect = 1;
        for (int i = 0; i < 20; i++) cyc();
        chk("flush_saturate", 32'(flush_count), CMAX);
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
            ex_memread = 1'($urandom); mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
            ex_redirect = ($urandom_range(0, 4) == 0);
            dmem_req = ($urandom_range(0, 3) == 0);
            dmem_ready = 1'($urandom);
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forwarding sequencer for the 5-stage MiniRISC-V pipeline (IF/ID/EX/MEM/WB). It detects load-use hazards, resolves EX-stage redirects (taken branch, jal, jalr) and freezes the pipeline while data memory is not ready. It drives pipeline-register enables and flushes, the EX forwarding muxes, and the `hazard`/`flush` inputs of Control, which zeroes control signals to form bubbles. It also keeps saturating stall/flush performance counters and a memory-timeout flag.

Parameters:
MEM_TIMEOUT, 64, number of consecutive MEM_WAIT cycles after which mem_timeout is set (must be >= 2).
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  synchronous active-low reset
id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads that source
ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX
ex_rd  in  5  destination register in EX
ex_memread  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved a taken branch, jal or jalr
mem_rd  in  5  destination register in MEM
mem_regwrite  in  1  MEM instruction writes the register file
wb_rd  in  5  destination register in WB
wb_regwrite  in  1  WB instruction writes the register file
dmem_req  in  1  MEM stage is issuing a load or store
dmem_ready  in  1  data memory completes the access this cycle
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register update enables
ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (NOP) on the next edge
pc_redirect  out  1  PC selects the EX target address
hazard  out  1  to Control: load-use bubble
flush  out  1  to Control: redirect squash
fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 10 MEM result, 01 WB result
stall_count, flush_count  out  CNT_W each  saturating performance counters
mem_timeout  out  1  sticky error flag

Behaviour:
- State register: RUN, MEM_WAIT. Reset (rst_n=0 at clk edge) → RUN, wait_cnt=0, counters=0, mem_timeout=0.
- Outputs are combinational from inputs and state. During reset all enables read 1 and all flushes 0.
- Transitions:
  - RUN→MEM_WAIT when dmem_req && !dmem_ready.
  - MEM_WAIT→RUN when dmem_ready.
  - Otherwise hold.
- memstall = dmem_req && !dmem_ready, evaluated in either state. Freezing starts in the same cycle the miss is seen.
- load_use = ex_memread && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- Priority is memstall > ex_redirect > load_use.
  - memstall: pc_en = ifid_en = idex_en = exmem_en = memwb_en = 0; memwb_flush = 1, so WB does not retire twice; all other flushes 0; hazard = flush = pc_redirect = 0. A redirect or load-use present in the same cycle is deferred: the inputs stay frozen and the event is re-evaluated later.
  - ex_redirect: all enables 1; pc_redirect = 1; ifid_flush = 1; idex_flush = 1; flush = 1; hazard = 0. A load-use in the same cycle is ignored because the ID instruction is squashed.
  - load_use: pc_en = 0, ifid_en = 0; idex_flush = 1; hazard = 1; all other enables 1. Exactly one bubble is inserted.
  - None: all enables 1, all flushes 0.
- Forwarding (independent of stalls), for each operand:
  - 10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rsX;
  - else 01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rsX;
  - else 00.
  - MEM has priority over WB. Register x0 never forwards.
- wait_cnt:
  - cleared on RUN→MEM_WAIT;
  - increments each cycle in MEM_WAIT while !dmem_ready;
  - saturates at MEM_TIMEOUT-1.
  - mem_timeout sets when wait_cnt == MEM_TIMEOUT-1 && !dmem_ready, and clears only on reset. The pipeline stays frozen; there is no recovery.
- stall_count increments in any cycle with memstall or load_use (effective, after priority). flush_count increments in cycles where flush=1. Both saturate at 2^CNT_W-1; there is no wrap.
- A reset asserted mid-MEM_WAIT returns to RUN on that edge regardless of dmem_ready.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle → hazard=1, pc_en=0, ifid_en=0, idex_flush=1, stall_count 0→1; next cycle with ex_memread=0 → all enables 1.
- x0 / unused sources: ex_rd=0 with id_rs1=0 → no stall. ex_rd=7, id_rs2=7, id_uses_rs2=0 → no stall.
- Redirect with simultaneous load-use: ex_redirect=1 and load_use true → flush=1, pc_redirect=1, ifid_flush=idex_flush=1, hazard=0, pc_en=1, flush_count=1.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 → all enables 0 and memwb_flush=1 for 3 cycles; state returns to RUN after the ready edge; stall_count=3; mem_timeout=0.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 → mem_timeout rises after the 4th wait cycle and stays 1 after dmem_ready=1; it clears only after rst_n=0 for one edge.
- Forwarding: mem_rd=ex_rs1=wb_rd=3 with both regwrite=1 → fwd_a=10; mem_regwrite=0 → fwd_a=01; ex_rs2=mem_rd=0 → fwd_b=00.
